// File: rtl/dmem_write_tracer.sv
// dmem_write_tracer
//   Snoops the CPU data-memory write port and records each qualifying write
//   as {cycle stamp, address, data}. Records are kept in an in-order FIFO and
//   drained through a valid/ready stream.
//
// Ports
//   Clk        single clock, rising edge
//   Reset      synchronous, active-low
//   TrkEn      capture enable (does not gate draining)
//   WrEn       CPU write strobe
//   WrAddr     CPU write address
//   WrData     CPU write data
//   TrkValid   head record available
//   TrkReady   consumer accepts head record
//   TrkStamp   head record cycle stamp (0 when TrkValid = 0)
//   TrkAddr    head record address     (0 when TrkValid = 0)
//   TrkData    head record data        (0 when TrkValid = 0)
//   Count      entries held, 0..DEPTH
//   Overflow   sticky, set when a record was dropped
//   DropCnt    dropped-record count, saturates at 0xFFFF
//   OvfClr     clears Overflow and DropCnt (a same-cycle drop wins)
module dmem_write_tracer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned STAMP_W = 32,
  parameter int unsigned LO_ADDR = 0,
  parameter int unsigned HI_ADDR = 24575
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     TrkEn,
  input  logic                     WrEn,
  input  logic [ADDR_W-1:0]        WrAddr,
  input  logic [DATA_W-1:0]        WrData,
  output logic                     TrkValid,
  input  logic                     TrkReady,
  output logic [STAMP_W-1:0]       TrkStamp,
  output logic [ADDR_W-1:0]        TrkAddr,
  output logic [DATA_W-1:0]        TrkData,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow,
  output logic [15:0]              DropCnt,
  input  logic                     OvfClr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned RW = STAMP_W + ADDR_W + DATA_W;

  localparam logic [ADDR_W-1:0] LO = ADDR_W'(LO_ADDR);
  localparam logic [ADDR_W-1:0] HI = ADDR_W'(HI_ADDR);

  logic [RW-1:0]      mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count_q;
  logic [STAMP_W-1:0] stamp_q;
  logic               ovf_q;
  logic [15:0]        drop_q;

  logic [ADDR_W:0]    lo_diff;
  logic [ADDR_W:0]    hi_diff;
  logic               in_win;
  logic               capture;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;
  logic [RW-1:0]      head;

  // Window test by borrow of an extended subtraction: avoids a constant
  // comparison when LO_ADDR is 0 and stays correct for any bounds.
  assign lo_diff = {1'b0, WrAddr} - {1'b0, LO};
  assign hi_diff = {1'b0, HI} - {1'b0, WrAddr};
  assign in_win  = !lo_diff[ADDR_W] && !hi_diff[ADDR_W];

  assign capture = WrEn & TrkEn & in_win;
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = TrkValid & TrkReady;
  // A full FIFO still accepts a capture when the head leaves in the same
  // cycle: the freed slot is the one being written.
  assign push    = capture & (!full | pop);
  assign drop    = capture & full & !pop;

  // Storage needs no reset; the read side is masked by TrkValid.
  always_ff @(posedge Clk) begin
    if (Reset && push) begin
      mem[wr_ptr] <= {stamp_q, WrAddr, WrData};
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      stamp_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      stamp_q <= stamp_q + STAMP_W'(1);

      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      // A drop in the same cycle as a clear restarts the count at one.
      if (drop) begin
        ovf_q <= 1'b1;
        if (OvfClr) begin
          drop_q <= 16'd1;
        end else if (drop_q != 16'hFFFF) begin
          drop_q <= drop_q + 16'd1;
        end
      end else if (OvfClr) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end
    end
  end

  assign head     = mem[rd_ptr];
  assign TrkValid = (count_q != '0);
  assign TrkStamp = TrkValid ? head[RW-1 -: STAMP_W]          : '0;
  assign TrkAddr  = TrkValid ? head[DATA_W +: ADDR_W]         : '0;
  assign TrkData  = TrkValid ? head[DATA_W-1:0]               : '0;
  assign Count    = count_q;
  assign Overflow = ovf_q;
  assign DropCnt  = drop_q;

endmodule

// File: tb/tb_dmem_write_tracer.sv
// Testbench for dmem_write_tracer: directed writes with expected records
// queued at issue time; a monitor compares each record as it is popped.
module tb_dmem_write_tracer;

  logic        Clk;
  logic        Reset;
  logic        TrkEn;
  logic        WrEn;
  logic [14:0] WrAddr;
  logic [15:0] WrData;
  logic        TrkValid;
  logic        TrkReady;
  logic [31:0] TrkStamp;
  logic [14:0] TrkAddr;
  logic [15:0] TrkData;
  logic [4:0]  Count;
  logic        Overflow;
  logic [15:0] DropCnt;
  logic        OvfClr;

  typedef struct {
    logic [31:0] stamp;
    logic [14:0] addr;
    logic [15:0] data;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        mon_e;
  int          nvec = 0;
  int          nerr = 0;
  int unsigned cyc  = 0;

  dmem_write_tracer #(
    .DEPTH(16), .ADDR_W(15), .DATA_W(16), .STAMP_W(32),
    .LO_ADDR(0), .HI_ADDR(24575)
  ) dut (
    .Clk(Clk), .Reset(Reset), .TrkEn(TrkEn), .WrEn(WrEn),
    .WrAddr(WrAddr), .WrData(WrData), .TrkValid(TrkValid),
    .TrkReady(TrkReady), .TrkStamp(TrkStamp), .TrkAddr(TrkAddr),
    .TrkData(TrkData), .Count(Count), .Overflow(Overflow),
    .DropCnt(DropCnt), .OvfClr(OvfClr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock; cyc is the stamp the next edge will apply to a write.
  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d, input bit cap);
    rec_t r;
    WrEn   = 1'b1;
    WrAddr = a;
    WrData = d;
    if (cap) begin
      r.stamp = cyc;
      r.addr  = a;
      r.data  = d;
      exp_q.push_back(r);
    end
    step();
    WrEn = 1'b0;
  endtask

  task automatic drain(input int n);
    TrkReady = 1'b1;
    repeat (n) step();
    TrkReady = 1'b0;
  endtask

  // Monitor: a record leaves at the next edge when valid & ready outside reset.
  initial begin
    forever begin
      @(negedge Clk);
      if (Reset && TrkValid && TrkReady) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_record: got addr 0x%0h data 0x%0h expected none", TrkAddr, TrkData);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rec_stamp", TrkStamp, mon_e.stamp);
          chk("rec_addr", 32'(TrkAddr), 32'(mon_e.addr));
          chk("rec_data", 32'(TrkData), 32'(mon_e.data));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b0; TrkEn = 1'b1; WrEn = 1'b0; WrAddr = '0; WrData = '0;
    TrkReady = 1'b0; OvfClr = 1'b0;

    // Reset values
    repeat (3) step();
    Reset = 1'b1;
    cyc   = 0;
    chk("rst_valid", 32'(TrkValid), 0);
    chk("rst_count", 32'(Count), 0);
    chk("rst_stamp", TrkStamp, 0);
    chk("rst_addr", 32'(TrkAddr), 0);
    chk("rst_data", 32'(TrkData), 0);
    chk("rst_ovf", 32'(Overflow), 0);
    chk("rst_dropcnt", 32'(DropCnt), 0);

    // Single capture in cycle 5, held for 10 cycles, then popped
    repeat (5) step();
    wr(15'h0010, 16'hBEEF, 1);
    chk("single_valid", 32'(TrkValid), 1);
    chk("single_count", 32'(Count), 1);
    chk("single_stamp", TrkStamp, 5);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_addr", 32'(TrkAddr), 32'h0010);
      chk("hold_data", 32'(TrkData), 32'hBEEF);
      chk("hold_stamp", TrkStamp, 5);
    end
    drain(1);
    chk("single_pop_valid", 32'(TrkValid), 0);
    chk("single_pop_count", 32'(Count), 0);

    // Filter and enable, plus window edges
    wr(15'h6001, 16'h1111, 0);
    chk("filter_count", 32'(Count), 0);
    TrkEn = 1'b0;
    wr(15'h0000, 16'h2222, 0);
    TrkEn = 1'b1;
    chk("disabled_count", 32'(Count), 0);
    chk("disabled_valid", 32'(TrkValid), 0);
    chk("filter_dropcnt", 32'(DropCnt), 0);
    wr(15'h5FFF, 16'hA5A5, 1);
    chk("hi_edge_count", 32'(Count), 1);
    wr(15'h6000, 16'h3333, 0);
    chk("above_hi_count", 32'(Count), 1);
    wr(15'h0000, 16'h0F0F, 1);
    chk("lo_edge_count", 32'(Count), 2);
    drain(2);
    chk("edges_drained", 32'(Count), 0);

    // Overflow: 20 writes into 16 slots
    for (int i = 0; i < 20; i++) begin
      wr(15'(16'h0100 + i), 16'(i), i < 16);
    end
    chk("ovf_count", 32'(Count), 16);
    chk("ovf_flag", 32'(Overflow), 1);
    chk("ovf_dropcnt", 32'(DropCnt), 4);
    drain(16);
    chk("ovf_drained", 32'(Count), 0);
    chk("ovf_sticky", 32'(Overflow), 1);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) begin
      wr(15'(16'h0200 + i), 16'(16'h0200 + i), 1);
    end
    chk("refill_count", 32'(Count), 16);
    TrkReady = 1'b1;
    for (int j = 0; j < 8; j++) begin
      wr(15'(16'h0300 + j), 16'(16'h0300 + j), 1);
      chk("fullpp_count", 32'(Count), 16);
    end
    TrkReady = 1'b0;
    chk("fullpp_dropcnt", 32'(DropCnt), 4);

    // Clear collides with a drop: drop wins
    OvfClr = 1'b1;
    wr(15'h0400, 16'h0400, 0);
    OvfClr = 1'b0;
    chk("clrdrop_ovf", 32'(Overflow), 1);
    chk("clrdrop_dropcnt", 32'(DropCnt), 1);
    chk("clrdrop_count", 32'(Count), 16);
    OvfClr = 1'b1;
    step();
    OvfClr = 1'b0;
    chk("clr_ovf", 32'(Overflow), 0);
    chk("clr_dropcnt", 32'(DropCnt), 0);
    drain(16);
    chk("fullpp_drained", 32'(Count), 0);

    // Reset mid-stream with 5 entries held
    for (int i = 0; i < 5; i++) begin
      wr(15'(16'h0500 + i), 16'(16'h0500 + i), 1);
    end
    chk("pre_rst_count", 32'(Count), 5);
    Reset    = 1'b0;
    TrkReady = 1'b1;
    WrEn     = 1'b1;
    WrAddr   = 15'h0050;
    WrData   = 16'h5555;
    step();
    WrEn = 1'b0;
    exp_q.delete();
    Reset    = 1'b1;
    TrkReady = 1'b0;
    cyc      = 0;
    chk("midrst_count", 32'(Count), 0);
    chk("midrst_valid", 32'(TrkValid), 0);
    chk("midrst_data", 32'(TrkData), 0);
    wr(15'h0042, 16'h1234, 1);
    chk("midrst_stamp", TrkStamp, 0);
    chk("midrst_new_count", 32'(Count), 1);
    drain(1);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
